spi_peripheral: RTL
===================

// Module: spi_peripheral
// PURPOSE
//  SPI target (peripheral) end of the SPI link driven by the Wally SPI controller. External SCLK, CS_n
//  and SDI are oversampled in the PCLK domain. Received frames go out on a valid/ready port, and
//  transmit bytes come in on a valid/ready port. Supports all four SckMode settings and 1-8 bit frames.
// PARAMETERS
//  SYNC_STAGES  2  flops in each SCLK/CS_n/SDI synchronizer (>=2)
// PORTS
//  PCLK         in   1  block clock; all logic on posedge PCLK
//  PRESET       in   1  asynchronous, active-high reset
//  SckMode      in   2  [1]=CPOL (SCLK idle level), [0]=CPHA (0: sample leading edge, 1: sample trailing)
//  FrameLength  in   4  bits per frame, 1..8; 0 and >8 are treated as 8
//  LsbFirst     in   1  1: shift LSB first; 0: MSB first
//  SCLK         in   1  serial clock from controller (asynchronous)
//  CS_n         in   1  chip select, active low (asynchronous)
//  SDI          in   1  serial data in, controller->peripheral (asynchronous)
//  SDO          out  1  serial data out, peripheral->controller
//  SDOEn        out  1  SDO output enable (pad tri-state control)
//  RxData       out  8  last received frame, right-justified, upper bits zero
//  RxValid      out  1  RxData holds an unconsumed frame
//  RxReady      in   1  consumer accepts RxData when RxValid&RxReady
//  TxData       in   8  next frame to send, right-justified
//  TxValid      in   1  TxData is offered
//  TxReady      out  1  holding register empty; TxData captured on TxValid&TxReady
//  RxOverrun    out  1  1-cycle pulse: frame completed while RxValid=1; new frame dropped
//  TxUnderrun   out  1  1-cycle pulse: frame loaded while holding empty; 8'h00 sent instead
//  FrameAbort   out  1  1-cycle pulse: CS_n deasserted with 0 < BitCount < FrameLength
// BEHAVIOUR
//  Reset values: SDO=0, SDOEn=0, RxData=0, RxValid=0, TxReady=1, all pulse outputs=0, state IDLE.
//  Sync/edge detection
//  - Each input passes through SYNC_STAGES flops, then one history flop for edge detection.
//  - Latency is SYNC_STAGES+1 PCLK from a pin edge to the internal event.
//  - SCLK high and low phases must each be >= SYNC_STAGES+2 PCLK; faster SCLK is unsupported.
//  - Leading edge = SCLK leaving CPOL; trailing edge = SCLK returning to CPOL.
//  - Sample edge = leading if CPHA=0, else trailing; the shift edge is the other one.
//  FSM (IDLE, ACTIVE)
//  - IDLE -> ACTIVE on the synced CS_n falling edge.
//    - SckMode, FrameLength and LsbFirst are latched at this point. They must not change while
//      CS_n is low.
//    - BitCount=0 and LoadPending=1.
//    - CPHA=0: the shift register loads immediately on CS_n falling.
//  - ACTIVE -> IDLE on the synced CS_n rising edge.
//    - SDOEn drops on the same cycle.
//    - Partial frames are discarded and pulse FrameAbort. The holding register is untouched.
//  - SDOEn = (state==ACTIVE). SDO = shift register bit [FrameLength-1] (MSB-first) or bit [0] (LSB-first).
//  Load and shift
//  - A load copies the holding register into the shift register, sets TxReady=1 and clears LoadPending.
//  - Load with the holding register empty: load 8'h00 and pulse TxUnderrun.
//  - On a shift edge with LoadPending=1: perform the load. This applies to CPHA=1 at every frame
//    start, and to CPHA=0 for frames after the first.
//  - On a shift edge with LoadPending=0: shift the shift register one position toward the output.
//  - On a sample edge: shift SDI into the receive register and increment BitCount.
//  Frame completion
//  - A frame completes when BitCount reaches FrameLength on a sample edge.
//  - If RxValid=0: RxData is written and RxValid=1 on the next cycle.
//  - If RxValid=1: RxOverrun pulses and RxData is kept.
//  - BitCount returns to 0 and LoadPending=1.
//  Handshakes and simultaneous events
//  - RxValid clears on RxValid&RxReady.
//  - Consume and completion on the same cycle: the new frame is written and RxValid stays 1,
//    with no overrun.
//  - TxReady drops the cycle after the TxValid&TxReady capture.
//  - Capture and load on the same cycle: the load takes the incoming TxData directly, with no
//    underrun, and TxReady stays 1.
//  - CS_n rise coinciding with completion: the frame completes and no abort is raised.
//  - PRESET asserted mid-frame returns everything to reset values immediately. Synchronizers reset
//    to CS_n=1 and SCLK=0.
// TESTING
//  1. Mode 0, FL=8, MSB-first, TxData=8'hA5 preloaded, controller sends 8'h3C
//     -> SDO shows 1,0,1,0,0,1,0,1; RxData=8'h3C, RxValid=1.
//  2. Mode 3, LSB-first, FL=4, TxData=8'h06, two back-to-back frames with the second Tx not supplied
//     -> SDO 0,1,1,0; second frame sends 0s and TxUnderrun pulses once.
//  3. Two frames received, RxReady held 0 -> RxOverrun pulses once; RxData keeps the first frame.
//  4. CS_n deasserted after 3 of 8 bits -> FrameAbort pulses, RxValid stays 0;
//     the next full frame 8'h81 is received correctly.
//  5. RxReady pulse coincides with completion of a second frame 8'h55 -> RxData=8'h55, RxValid=1, no overrun.
//  6. PRESET pulsed mid-frame -> all outputs at reset values within 1 PCLK; the next frame is received cleanly.

Source files
------------

// File: rtl/spi_peripheral.sv
// SPI peripheral: oversamples SCLK/CS_n/SDI in the PCLK domain, all four SCLK modes, 1-8 bit frames.
// Ports: PCLK/PRESET; SckMode, FrameLength, LsbFirst config; SCLK, CS_n, SDI, SDO, SDOEn pins;
//        Rx valid/ready (RxData, RxValid, RxReady); Tx valid/ready (TxData, TxValid, TxReady);
//        RxOverrun, TxUnderrun, FrameAbort status pulses.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [1:0] SckMode,
  input  logic [3:0] FrameLength,
  input  logic       LsbFirst,
  input  logic       SCLK,
  input  logic       CS_n,
  input  logic       SDI,
  output logic       SDO,
  output logic       SDOEn,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       RxOverrun,
  output logic       TxUnderrun,
  output logic       FrameAbort
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic sclk_q, cs_q;
  logic sclk_s, cs_s, sdi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead, trail, active, sample, shift, start, load;
  logic capture, complete;

  logic       cpol, cpha, lsb;
  logic [3:0] fl, fl_in, bit_cnt, cnt_inc, partial;
  logic       load_pending;
  logic [7:0] tx_sh, rx_sh, rx_next, hold, load_src;
  logic       hold_full;

  // Synchronizers idle at CS_n=1, SCLK=0; one extra history flop for edges.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SDI};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  assign active = (state == ACTIVE);
  assign lead   = cpol ? sclk_fall : sclk_rise;
  assign trail  = cpol ? sclk_rise : sclk_fall;
  assign sample = active & (cpha ? trail : lead);
  assign shift  = active & (cpha ? lead : trail);
  assign start  = (state == IDLE) & cs_fall;

  // CPHA=0 must present its first bit before the first SCLK edge.
  assign load    = (shift & load_pending) | (start & ~SckMode[0]);
  assign capture = TxValid & TxReady;

  // Same-cycle capture feeds the load directly, so no underrun then.
  assign load_src = hold_full ? hold : (capture ? TxData : 8'h00);

  assign fl_in = (FrameLength == 4'd0 || FrameLength > 4'd8) ? 4'd8 : FrameLength;

  assign cnt_inc  = bit_cnt + 4'd1;
  assign complete = sample & (cnt_inc == fl);
  assign partial  = sample ? cnt_inc : bit_cnt;

  // LSB-first lands each bit at fl-1 and walks down, keeping the frame right-justified.
  assign rx_next = lsb ? ((rx_sh >> 1) | ({7'd0, sdi_s} << (fl - 4'd1)))
                       : {rx_sh[6:0], sdi_s};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (cs_fall) state_n = ACTIVE;
      ACTIVE: if (cs_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    SDOEn   = active;
    SDO     = lsb ? tx_sh[0] : tx_sh[3'(fl - 4'd1)];
    TxReady = ~hold_full;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cpol         <= 1'b0;
      cpha         <= 1'b0;
      lsb          <= 1'b0;
      fl           <= 4'd8;
      bit_cnt      <= 4'd0;
      load_pending <= 1'b0;
      tx_sh        <= 8'h00;
      rx_sh        <= 8'h00;
      hold         <= 8'h00;
      hold_full    <= 1'b0;
      RxData       <= 8'h00;
      RxValid      <= 1'b0;
      RxOverrun    <= 1'b0;
      TxUnderrun   <= 1'b0;
      FrameAbort   <= 1'b0;
    end else begin
      RxOverrun  <= 1'b0;
      TxUnderrun <= 1'b0;
      FrameAbort <= 1'b0;

      if (load) begin
        hold_full  <= 1'b0;
        TxUnderrun <= ~hold_full & ~capture;
      end else if (capture) begin
        hold      <= TxData;
        hold_full <= 1'b1;
      end

      if (start) begin
        cpol         <= SckMode[1];
        cpha         <= SckMode[0];
        lsb          <= LsbFirst;
        fl           <= fl_in;
        bit_cnt      <= 4'd0;
        rx_sh        <= 8'h00;
        load_pending <= 1'b1;
      end

      if (load) begin
        tx_sh        <= load_src;
        load_pending <= 1'b0;
      end else if (shift) begin
        tx_sh <= lsb ? (tx_sh >> 1) : (tx_sh << 1);
      end

      if (RxValid && RxReady) RxValid <= 1'b0;

      if (sample) begin
        if (complete) begin
          bit_cnt      <= 4'd0;
          rx_sh        <= 8'h00;
          load_pending <= 1'b1;
          if (!RxValid || RxReady) begin
            RxData  <= rx_next;
            RxValid <= 1'b1;
          end else begin
            RxOverrun <= 1'b1;
          end
        end else begin
          bit_cnt <= cnt_inc;
          rx_sh   <= rx_next;
        end
      end

      if (active && cs_rise && !complete) begin
        bit_cnt    <= 4'd0;
        rx_sh      <= 8'h00;
        FrameAbort <= (partial != 4'd0);
      end
    end
  end

endmodule
